// File: rtl/arb4_rr_ctrl.sv
// Four-client bus arbiter: round-robin or fixed priority, registered one-hot grant
// plus encoded owner index, with an optional hold limit that forces release and pulses timeout.
module arb4_rr_ctrl #(
    parameter int MAX_HOLD  = 8,
    parameter int FIXED_PRI = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam bit         HOLD_LIMITED = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST    = HOLD_LIMITED ? 8'(MAX_HOLD - 1) : 8'd0;

    // Shared 4-to-2 priority encoder: highest set bit wins, 00 when nothing is set.
    function automatic logic [1:0] pri_enc4(input logic [3:0] v);
        logic [1:0] idx;
        if (v[3])      idx = 2'd3;
        else if (v[2]) idx = 2'd2;
        else if (v[1]) idx = 2'd1;
        else           idx = 2'd0;
        return idx;
    endfunction

    // Round-robin pick built on the encoder: the request vector is rotated so the first
    // index in search order (last+1) lands on bit 3, then the encoded slot is mapped back.
    function automatic logic [1:0] rr_pick(input logic [3:0] v, input logic [1:0] last);
        logic [3:0] srch;
        logic [1:0] pos;
        for (int k = 0; k < 4; k++) begin
            srch[3 - k] = v[last + 2'(k + 1)];
        end
        pos = pri_enc4(srch);
        return last + 2'd1 + (2'd3 - pos);
    endfunction

    state_t     state_q,     state_d;
    logic [3:0] gnt_q,       gnt_d;
    logic [1:0] gnt_id_q,    gnt_id_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       timeout_q,   timeout_d;
    logic [7:0] hold_cnt_q,  hold_cnt_d;
    logic [1:0] last_id_q,   last_id_d;

    logic [1:0] win_id;
    logic       owner_req;
    logic       hold_done;

    always_comb begin
        // NOTE: every next-state signal is given its hold value before the case so that no
        // path through the decode leaves one unassigned and infers a latch.
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        last_id_d   = last_id_q;

        win_id    = (FIXED_PRI != 0) ? pri_enc4(req) : rr_pick(req, last_id_q);
        owner_req = req[gnt_id_q];
        hold_done = HOLD_LIMITED && (hold_cnt_q == HOLD_LAST);

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d     = BUSY;
                    gnt_d       = 4'b0001 << win_id;
                    gnt_id_d    = win_id;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = 8'd0;
                    last_id_d   = win_id;
                end
            end
            BUSY: begin
                // A dropped request always wins over the limit, so timeout only
                // fires when the owner was still asking for the bus.
                if (!owner_req || hold_done) begin
                    state_d     = IDLE;
                    gnt_d       = 4'b0000;
                    gnt_id_d    = 2'd0;
                    gnt_valid_d = 1'b0;
                    timeout_d   = owner_req;
                end else if (hold_cnt_q != 8'hFF) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: registers update with non-blocking assignments so every flop sees the
    // pre-edge value of the others regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= 4'b0000;
            gnt_id_q    <= 2'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= 8'd0;
            last_id_q   <= 2'd3;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
            last_id_q   <= last_id_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_arb4_rr_ctrl.sv
// Self-checking bench: four arbiter configurations share one request bus and are compared
// every cycle against an ownership-level model, plus directed literal scenarios.
module tb_arb4_rr_ctrl;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;

    logic [3:0] gnt_w [N];
    logic [1:0] id_w  [N];
    logic       vld_w [N];
    logic       to_w  [N];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    arb4_rr_ctrl #(.MAX_HOLD(8), .FIXED_PRI(0)) u0 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_w[0]), .gnt_id(id_w[0]), .gnt_valid(vld_w[0]), .timeout(to_w[0]));
    arb4_rr_ctrl #(.MAX_HOLD(4), .FIXED_PRI(0)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_w[1]), .gnt_id(id_w[1]), .gnt_valid(vld_w[1]), .timeout(to_w[1]));
    arb4_rr_ctrl #(.MAX_HOLD(3), .FIXED_PRI(1)) u2 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_w[2]), .gnt_id(id_w[2]), .gnt_valid(vld_w[2]), .timeout(to_w[2]));
    arb4_rr_ctrl #(.MAX_HOLD(0), .FIXED_PRI(0)) u3 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_w[3]), .gnt_id(id_w[3]), .gnt_valid(vld_w[3]), .timeout(to_w[3]));

    function automatic int mh_of(input int i);
        case (i)
            0:       return 8;
            1:       return 4;
            2:       return 3;
            default: return 0;
        endcase
    endfunction

    function automatic bit fx_of(input int i);
        return (i == 2);
    endfunction

    // Model: owner (-1 = none), cycles granted so far, last winner, timeout pulse.
    int m_owner [N];
    int m_held  [N];
    int m_last  [N];
    bit m_to    [N];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_owner[i] = -1;
            m_held[i]  = 0;
            m_last[i]  = 3;
            m_to[i]    = 1'b0;
        end
    endtask

    task automatic model_step(input logic [3:0] r);
        for (int i = 0; i < N; i++) begin
            int w;
            w = -1;
            m_to[i] = 1'b0;
            if (m_owner[i] < 0) begin
                if (fx_of(i)) begin
                    for (int b = 0; b < 4; b++) if (r[b]) w = b;
                end else begin
                    for (int k = 3; k >= 0; k--) if (r[(m_last[i] + 1 + k) % 4]) w = (m_last[i] + 1 + k) % 4;
                end
                if (w >= 0) begin
                    m_owner[i] = w;
                    m_held[i]  = 1;
                    m_last[i]  = w;
                end
            end else if (!r[m_owner[i]]) begin
                m_owner[i] = -1;
            end else if (mh_of(i) != 0 && m_held[i] == mh_of(i)) begin
                m_owner[i] = -1;
                m_to[i]    = 1'b1;
            end else begin
                m_held[i]++;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else        model_step(req);
    end

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            logic [3:0] eg;
            logic [1:0] eid;
            eg  = (m_owner[i] < 0) ? 4'b0000 : 4'(1 << m_owner[i]);
            eid = (m_owner[i] < 0) ? 2'd0 : 2'(m_owner[i]);
            check($sformatf("model u%0d.gnt", i),       8'(gnt_w[i]), 8'(eg));
            check($sformatf("model u%0d.gnt_id", i),    8'(id_w[i]),  8'(eid));
            check($sformatf("model u%0d.gnt_valid", i), 8'(vld_w[i]), 8'(m_owner[i] >= 0));
            check($sformatf("model u%0d.timeout", i),   8'(to_w[i]),  8'(m_to[i]));
        end
    end

    logic [3:0] fp_req [6];
    logic [1:0] fp_id  [6];

    initial begin
        model_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        fp_req[0] = 4'b0001; fp_id[0] = 2'd0;
        fp_req[1] = 4'b0010; fp_id[1] = 2'd1;
        fp_req[2] = 4'b0110; fp_id[2] = 2'd2;
        fp_req[3] = 4'b1010; fp_id[3] = 2'd3;
        fp_req[4] = 4'b1100; fp_id[4] = 2'd3;
        fp_req[5] = 4'b0000; fp_id[5] = 2'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst gnt",       8'(gnt_w[0]), 8'h00);
        check("rst gnt_id",    8'(id_w[0]),  8'h00);
        check("rst gnt_valid", 8'(vld_w[0]), 8'h00);
        check("rst timeout",   8'(to_w[0]),  8'h00);

        // First arbitration on the first edge after reset release
        rst_n = 1'b1;
        req   = 4'b0100;
        @(negedge clk);
        check("first grant gnt",    8'(gnt_w[0]), 8'h04);
        check("first grant gnt_id", 8'(id_w[0]),  8'h02);

        // Reset mid-grant, asserted between edges
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst gnt",       8'(gnt_w[0]), 8'h00);
        check("midrst gnt_id",    8'(id_w[0]),  8'h00);
        check("midrst gnt_valid", 8'(vld_w[0]), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after midrst gnt", 8'(gnt_w[0]), 8'h04);

        // Single request, MAX_HOLD=8
        req = 4'b0000;
        repeat (2) @(negedge clk);
        req = 4'b0100;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("single c%0d gnt", c),    8'(gnt_w[0]), (c <= 3) ? 8'h04 : 8'h00);
            check($sformatf("single c%0d gnt_id", c), 8'(id_w[0]),  (c <= 3) ? 8'h02 : 8'h00);
            check($sformatf("single c%0d timeout", c), 8'(to_w[0]), 8'h00);
            if (c == 3) req = 4'b0000;
        end

        // Round-robin rotation from reset, MAX_HOLD=4, all requesting
        @(negedge clk);
        #2 rst_n = 1'b0;
        req = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 25; j++) begin
            logic [7:0] eg;
            logic [7:0] eto;
            @(negedge clk);
            if ((j % 5) < 4) begin
                eg  = 8'(1 << ((j / 5) % 4));
                eto = 8'h00;
            end else begin
                eg  = 8'h00;
                eto = 8'h01;
            end
            check($sformatf("rr j%0d gnt", j),     8'(gnt_w[1]), eg);
            check($sformatf("rr j%0d timeout", j), 8'(to_w[1]),  eto);
        end

        // Fixed priority patterns from IDLE
        for (int p = 0; p < 6; p++) begin
            req = 4'b0000;
            repeat (2) @(negedge clk);
            req = fp_req[p];
            @(negedge clk);
            check($sformatf("fixed p%0d gnt_valid", p), 8'(vld_w[2]), (p < 5) ? 8'h01 : 8'h00);
            check($sformatf("fixed p%0d gnt_id", p),    8'(id_w[2]),  8'(fp_id[p]));
        end

        // Owner drops in the same cycle the limit would fire, MAX_HOLD=3
        req = 4'b0000;
        repeat (2) @(negedge clk);
        req = 4'b0010;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("simrel c%0d gnt", c),     8'(gnt_w[2]), (c <= 3) ? 8'h02 : 8'h00);
            check($sformatf("simrel c%0d timeout", c), 8'(to_w[2]),  8'h00);
            if (c == 3) req = 4'b0000;
        end

        // Unlimited hold with a competing higher index
        req = 4'b0000;
        repeat (2) @(negedge clk);
        req = 4'b0001;
        @(negedge clk);
        check("unlim start gnt", 8'(gnt_w[3]), 8'h01);
        req = 4'b1001;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            check($sformatf("unlim n%0d gnt", n),     8'(gnt_w[3]), 8'h01);
            check($sformatf("unlim n%0d timeout", n), 8'(to_w[3]),  8'h00);
        end
        req = 4'b1000;
        @(negedge clk);
        check("unlim release gnt", 8'(gnt_w[3]), 8'h00);
        @(negedge clk);
        check("unlim next owner gnt", 8'(gnt_w[3]), 8'h08);

        // Randomized traffic with occasional asynchronous resets
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
            end
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arb4_rr_ctrl.md
# arb4_rr_ctrl

Four-requester bus arbiter that shares one downstream resource between four clients. It is built around the team's 4-to-2 priority encoder function. It registers a one-hot grant plus its 2-bit encoded index, and holds the grant until the owner drops its request or a hold limit expires. The mode is selectable: round-robin, or fixed priority with the same ordering as the encoder (bit 3 highest).

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per ownership.
  - Range 0..255.
  - 0 means unlimited, with no timeout.
- `FIXED_PRI`, default 0:
  - 0 selects round-robin.
  - 1 selects fixed priority, req[3] > req[2] > req[1] > req[0].

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  request per client; level-sensitive; held high for as long as the client wants the resource.
- `gnt`  out  4  one-hot grant, registered; 0000 when no owner.
- `gnt_id`  out  2  encoded index of the owner, registered; 00 when `gnt_valid`=0.
- `gnt_valid`  out  1  high while `gnt` is nonzero.
- `timeout`  out  1  one-cycle pulse marking a forced release due to `MAX_HOLD`.

## Operation
- State machine with two states.
  - IDLE (reset state): gnt=0000.
  - BUSY: exactly one gnt bit high.
- IDLE, when req=0000: stay in IDLE.
- IDLE, when any req bit is high: pick a winner, then go to BUSY.
  - gnt becomes onehot(winner) and gnt_id=winner.
  - hold_cnt is cleared to 0.
  - last_id is set to winner.
- Winner selection with FIXED_PRI=0: search order is last_id+1, +2, +3, +0 (mod 4). The first set req bit wins.
- Winner selection with FIXED_PRI=1: the highest set req index wins, irrespective of last_id.
- BUSY, owner still requesting: hold_cnt increments each cycle.
- BUSY, req[gnt_id] low: normal release. Go to IDLE; timeout stays 0.
- BUSY, forced release: occurs when MAX_HOLD≠0, req[gnt_id] is still high, and hold_cnt==MAX_HOLD-1.
  - Go to IDLE and set timeout=1 for one cycle.
- Owner drops req in the same cycle as the limit: counts as a normal release; no timeout.
- Requests from non-owners during BUSY are ignored. They are neither queued nor latched; they are re-sampled in IDLE.
- A timed-out owner that keeps requesting stays eligible.
  - Round-robin: it ranks last.
  - Fixed priority: it wins again immediately if it is still the highest.
- hold_cnt is 8 bits and saturates (it never wraps). It is only compared when MAX_HOLD≠0.
- Reset values (asynchronous, applied immediately when rst_n falls, including mid-grant):
  - State: IDLE.
  - gnt=0000, gnt_id=00, gnt_valid=0, timeout=0.
  - hold_cnt=0, last_id=3, so the first round-robin search starts at 0.

## Timing
- Grant latency: req sampled high in IDLE cycle t → gnt valid in cycle t+1.
- Ownership length: at most MAX_HOLD cycles of gnt high per grant.
- Release: owner's req sampled low in cycle t → gnt=0000 in cycle t+1, which is the IDLE arbitration cycle.
  - The next grant is visible in t+2 at the earliest.
  - There is a guaranteed one-cycle dead gap between owners.
- timeout is high in exactly the first gnt=0000 cycle after a forced release, and low otherwise.
- All outputs are registered; there is no combinational path from req to any output.
- Release of rst_n: the first arbitration happens on the first rising edge after rst_n is deasserted.

## Test plan
- **Reset mid-grant.** Setup: req=0100, owner 2 granted. Stimulus: drive rst_n=0 asynchronously between edges. Required: gnt=0000, gnt_id=00, gnt_valid=0 immediately. After release with req=0100: gnt=0100 one cycle later.
- **Single request.** Stimulus: req=0100 from cycle 0, dropped in cycle 3 (MAX_HOLD=8). Required:
  - gnt=0100 and gnt_id=10 for cycles 1–3.
  - gnt=0000 in cycle 4.
  - timeout=0 throughout.
- **Round-robin rotation.** Stimulus: MAX_HOLD=4, FIXED_PRI=0, req=1111 held. Required:
  - Owners in order 0,1,2,3,0.
  - Each owner holds for 4 cycles, followed by 1 dead cycle.
  - timeout=1 in every dead cycle.
- **Fixed priority.** Stimulus: FIXED_PRI=1; apply each req pattern from IDLE. Required gnt_id:
  - req=0001 → 00; 0010 → 01; 0110 → 10.
  - req=1010 → 11; 1100 → 11.
  - req=0000 → no grant.
- **Simultaneous release and limit.** Stimulus: MAX_HOLD=3; owner 1 drops req in its 3rd grant cycle. Required: gnt=0000 next cycle with timeout=0.
- **Unlimited hold.** Stimulus: MAX_HOLD=0, req=0001 for 300 cycles, with req[3] also high. Required:
  - gnt=0001 continuously (hold_cnt saturates with no effect).
  - timeout never asserted.
  - Owner 3 is granted only after req[0] drops.
